seeded_fixed_sqrt: RTL and testbench

- Iterative digit-by-digit square root for unsigned fixed-point radicands with FRAC fractional bits. The result has the same fractional format.
- Sits directly downstream of the last-set-bit locator. It consumes that block's 6-bit location to skip root bits that are known to be zero, which shortens latency for small radicands.
- Used in the FPGA datapath for vector-length / normalisation work.
- One result bit is resolved per clock. Start/busy/done handshake.

---
 rtl/seeded_fixed_sqrt_if.sv | 36 +++
 rtl/seeded_fixed_sqrt.sv | 137 +++++++++++++
 tb/tb_seeded_fixed_sqrt.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seeded_fixed_sqrt_if.sv
// Request/response bundle for seeded_fixed_sqrt: operand, seed and start in; busy/done/root out.
// The producer side uses the master modport, the square-root unit the slave modport.
interface seeded_fixed_sqrt_if #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned FRAC  = 4
);
    localparam int unsigned ROOT_W = (WIDTH + FRAC) / 2;

    logic              start;
    logic [WIDTH-1:0]  radicand;
    logic [5:0]        location;
    logic              seed_en;
    logic              busy;
    logic              done;
    logic [ROOT_W-1:0] root;

    modport master (
        output start,
        output radicand,
        output location,
        output seed_en,
        input  busy,
        input  done,
        input  root
    );

    modport slave (
        input  start,
        input  radicand,
        input  location,
        input  seed_en,
        output busy,
        output done,
        output root
    );
endinterface

// File: rtl/seeded_fixed_sqrt.sv
// Bit-serial fixed-point square root, one root bit per clock, starting at a bit index
// seeded from the upstream last-set-bit locator so small radicands finish early.
module seeded_fixed_sqrt #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned FRAC  = 4
) (
    input  logic               clk,
    input  logic               rst_,
    seeded_fixed_sqrt_if.slave bus
);
    localparam int unsigned ROOT_W = (WIDTH + FRAC) / 2;
    localparam int unsigned X_W    = 2 * ROOT_W;
    localparam int unsigned BIT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
    localparam logic [BIT_W-1:0] TOP_BIT = BIT_W'(ROOT_W - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [ROOT_W-1:0] root_w_q, root_w_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [BIT_W-1:0]  bit_q, bit_d;

    logic              accept;
    int unsigned       seed_sum;
    logic [BIT_W-1:0]  first_bit;
    logic [ROOT_W-1:0] trial;
    logic [X_W-1:0]    trial_sq;
    logic              trial_ok;

    // Requests are only taken in IDLE; busy and DONE cycles drop them.
    always_comb begin
        accept = (state_q == StIdle) && bus.start;
    end

    // Seeded start bit, clamped to the top root bit; the seed is trusted otherwise.
    always_comb begin
        seed_sum  = 32'(bus.location) + FRAC;
        first_bit = TOP_BIT;
        if (bus.seed_en && (seed_sum < ROOT_W - 1)) begin
            first_bit = BIT_W'(seed_sum);
        end
    end

    // Full-width trial square: trial < 2^ROOT_W, so the product always fits in X_W bits.
    always_comb begin
        trial    = root_w_q | (ROOT_W'(1) << bit_q);
        trial_sq = X_W'(trial) * X_W'(trial);
        trial_ok = (trial_sq <= x_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (bit_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath next-state
    always_comb begin
        x_d      = x_q;
        root_w_d = root_w_q;
        root_d   = root_q;
        bit_d    = bit_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    x_d      = X_W'(bus.radicand) << FRAC;
                    root_w_d = '0;
                    bit_d    = first_bit;
                end
            end
            StCalc: begin
                if (trial_ok) begin
                    root_w_d = trial;
                end
                if (bit_q != '0) begin
                    bit_d = bit_q - BIT_W'(1);
                end else begin
                    // Publish on the last bit so root is already valid while done is high.
                    root_d = trial_ok ? trial : root_w_q;
                end
            end
            StDone: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst_) begin
            x_q      <= '0;
            root_w_q <= '0;
            root_q   <= '0;
            bit_q    <= '0;
        end else begin
            x_q      <= x_d;
            root_w_q <= root_w_d;
            root_q   <= root_d;
            bit_q    <= bit_d;
        end
    end

    // Outputs
    always_comb begin
        bus.busy = (state_q == StCalc);
        bus.done = (state_q == StDone);
        bus.root = root_q;
    end
endmodule

// File: tb/tb_seeded_fixed_sqrt.sv
// Directed and swept checks of seeded_fixed_sqrt: root value, latency, handshake and reset.
module tb_seeded_fixed_sqrt;
    logic clk = 1'b0;
    logic rst_ = 1'b1;
    int   n_err = 0;
    int   n_checks = 0;

    seeded_fixed_sqrt_if #(.WIDTH(12), .FRAC(4)) bus ();

    seeded_fixed_sqrt #(.WIDTH(12), .FRAC(4)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Locator model: seed derived from the radicand's highest set bit.
    function automatic logic [5:0] loc_of(input logic [11:0] r);
        int m = -1;
        for (int i = 0; i < 12; i++) if (r[i]) m = i;
        if (m < 3) return 6'd0;
        return 6'((m - 3) / 2);
    endfunction

    // One operation: start in an idle cycle, disturb inputs afterwards, wait for done.
    task automatic run_op(input string tag, input logic [11:0] rad, input logic [5:0] loc,
                          input logic sen, input int exp_lat, input logic [7:0] exp_root);
        int cyc;
        @(negedge clk);
        bus.radicand = rad;
        bus.location = loc;
        bus.seed_en  = sen;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.radicand = ~rad;
        bus.location = 6'd0;
        bus.seed_en  = ~sen;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " root"}, 32'(bus.root), 32'(exp_root));
        check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int dn;
        bus.start    = 1'b0;
        bus.radicand = '0;
        bus.location = '0;
        bus.seed_en  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset root", 32'(bus.root), 32'd0);
        @(negedge clk);
        rst_ = 1'b0;

        // Directed vectors
        run_op("4.0 seeded",   12'h040, 6'd1, 1'b1, 7, 8'h20);
        run_op("2.25 seeded",  12'h024, 6'd1, 1'b1, 7, 8'h18);
        run_op("0.25 seeded",  12'h004, 6'd0, 1'b1, 6, 8'h08);
        run_op("max clamped",  12'hFFF, 6'd4, 1'b1, 9, 8'hFF);
        run_op("zero",         12'h000, 6'd0, 1'b1, 6, 8'h00);
        run_op("4.0 unseeded", 12'h040, 6'd1, 1'b0, 9, 8'h20);

        // Starts during busy and during the done cycle are ignored
        @(negedge clk);
        bus.radicand = 12'h024;
        bus.location = 6'd1;
        bus.seed_en  = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy after accept", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.radicand = 12'h004;
        bus.location = 6'd0;
        bus.seed_en  = 1'b1;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 2;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("ignored-start latency", cyc, 9);
        check("ignored-start root", 32'(bus.root), 32'h18);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("start in done cycle busy", 32'(bus.busy), 32'd0);
        check("start in done cycle done", 32'(bus.done), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("root holds", 32'(bus.root), 32'h18);
        check("idle stays idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of a computation
        @(negedge clk);
        bus.radicand = 12'hFFF;
        bus.location = 6'd4;
        bus.seed_en  = 1'b1;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        check("mid reset busy", 32'(bus.busy), 32'd0);
        check("mid reset done", 32'(bus.done), 32'd0);
        check("mid reset root", 32'(bus.root), 32'd0);
        @(negedge clk);
        rst_ = 1'b0;
        dn = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dn++;
        end
        check("no done after reset", dn, 0);
        run_op("after reset", 12'h024, 6'd1, 1'b1, 7, 8'h18);

        // Sweep every radicand with a consistent seed and random seed enable
        for (int r = 0; r < 4096; r++) begin
            logic [5:0] loc;
            logic       sen;
            int         b0;
            loc = loc_of(12'(r));
            sen = 1'($urandom_range(0, 1));
            b0  = 7;
            if (sen && (int'(loc) + 4 < 7)) b0 = int'(loc) + 4;
            run_op($sformatf("sweep %03h", r), 12'(r), loc, sen, b0 + 2, 8'(isqrt(r * 16)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
